// File: rtl/pe2_writeback_collector.sv
// pe2_writeback_collector
// Consumer end of the PE2 result path. Each accepted issue is tracked through a
// tap line for the latency of the current pass mode. The matching PE2_out3/out4
// pair is captured into a small FIFO and written back to coefficient RAM as one
// two-port write. Issue credit covers both in-flight and buffered results, so the
// FIFO can never overflow.
module pe2_writeback_collector #(
   parameter int DATA_W     = 24,
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int LAT_FWD    = 2,
   parameter int LAT_KINV   = 3,
   parameter int LAT_DINV   = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              KD_mode,
   input  logic              sel_1,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   input  logic [ADDR_W-1:0] num_pairs,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [DATA_W-1:0] PE2_out3,
   input  logic [DATA_W-1:0] PE2_out4,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr0,
   output logic [DATA_W-1:0] wr_data0,
   output logic [ADDR_W-1:0] wr_addr1,
   output logic [DATA_W-1:0] wr_data1,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int LAT_MAX01 = (LAT_FWD > LAT_KINV) ? LAT_FWD : LAT_KINV;
   localparam int LAT_MAX   = (LAT_MAX01 > LAT_DINV) ? LAT_MAX01 : LAT_DINV;
   localparam int LAT_W     = $clog2(LAT_MAX + 1);
   localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W     = $clog2(LAT_MAX + FIFO_DEPTH + 1);
   localparam int PAIR_W    = 2 * DATA_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Pass control
   state_t              r_state;
   logic [LAT_W-1:0]    r_lat;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   r_stride;
   logic [ADDR_W-1:0]   r_num;
   logic [ADDR_W-1:0]   r_issued;
   logic [ADDR_W-1:0]   r_k;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   // Latency tracking and result buffer
   logic [LAT_MAX-1:0]  r_tap;
   logic [PAIR_W-1:0]   r_mem [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic [LAT_MAX-1:0]  w_tap_mask;
   logic [LAT_MAX-1:0]  w_tap_last;
   logic [OCC_W-1:0]    w_inflight;
   logic [OCC_W-1:0]    w_occupancy;
   logic                w_issue_ready;
   logic                w_accept;
   logic                w_push;
   logic                w_wr_en;
   logic                w_pop;
   logic [ADDR_W:0]     w_issued_inc;
   logic [ADDR_W:0]     w_k_inc;
   logic                w_last_issue;
   logic                w_last_write;
   logic [LAT_W-1:0]    w_start_lat;
   logic [PAIR_W-1:0]   w_head;

   // Per-tap decode: which taps are live for this pass, and which one is the capture tap
   generate
      for (genvar gi = 0; gi < LAT_MAX; gi++) begin : g_tap
         assign w_tap_mask[gi] = (LAT_W'(gi) < r_lat);
         assign w_tap_last[gi] = (LAT_W'(gi + 1) == r_lat);
      end
   endgenerate

   // Count issues still travelling through PE2
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < LAT_MAX; i++) begin
         w_inflight = w_inflight + OCC_W'(r_tap[i]);
      end
   end

   assign w_occupancy   = w_inflight + OCC_W'(r_count);
   assign w_issue_ready = (r_state == S_RUN) && (w_occupancy < OCC_W'(FIFO_DEPTH));
   assign w_accept      = issue_valid & w_issue_ready;
   assign w_push        = |(r_tap & w_tap_last);
   assign w_wr_en       = (r_count != '0);
   assign w_pop         = w_wr_en & wr_ready;
   assign w_issued_inc  = {1'b0, r_issued} + (ADDR_W + 1)'(1);
   assign w_k_inc       = {1'b0, r_k} + (ADDR_W + 1)'(1);
   assign w_last_issue  = w_accept & (w_issued_inc == {1'b0, r_num});
   assign w_last_write  = w_pop & (w_k_inc == {1'b0, r_num});
   assign w_start_lat   = sel_1 ? (KD_mode ? LAT_W'(LAT_DINV) : LAT_W'(LAT_KINV))
                                : LAT_W'(LAT_FWD);

   // Pass FSM: mode latch, issue/write counters, busy/done/err outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_lat    <= '0;
         r_base   <= '0;
         r_stride <= '0;
         r_num    <= '0;
         r_issued <= '0;
         r_k      <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_issued <= r_issued + ADDR_W'(1);
         end
         if (w_pop) begin
            r_k <= r_k + ADDR_W'(1);
         end
         if (issue_valid & ~w_issue_ready) begin
            r_err <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_lat    <= w_start_lat;
                  r_base   <= base_addr;
                  r_stride <= stride;
                  r_num    <= num_pairs;
                  r_issued <= '0;
                  r_k      <= '0;
                  r_busy   <= 1'b1;
                  if (num_pairs == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_last_issue) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // The last write accepted implies tap line and FIFO are empty
               if (w_last_write) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Tap line: bit 0 marks a fresh issue, taps beyond the pass latency are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tap <= '0;
      end else begin
         r_tap <= {r_tap[LAT_MAX-2:0], w_accept} & w_tap_mask;
      end
   end

   // FIFO storage: capture the PE2 pair on the cycle its issue reaches the capture tap
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {PE2_out3, PE2_out4};
      end
   end

   // FIFO pointers and fill level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push & ~w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (~w_push & w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   assign w_head      = r_mem[r_rd_ptr];
   assign issue_ready = w_issue_ready;
   assign wr_en       = w_wr_en;
   assign wr_addr0    = r_base + r_k;
   assign wr_addr1    = r_base + r_k + r_stride;
   assign wr_data0    = w_wr_en ? w_head[PAIR_W-1:DATA_W] : '0;
   assign wr_data1    = w_wr_en ? w_head[DATA_W-1:0] : '0;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;

endmodule

// File: tb/tb_pe2_writeback_collector.sv
// tb_pe2_writeback_collector
// Randomized bench with a transaction-level reference model: every accepted issue
// is remembered with the cycle it entered PE2; its result is whatever PE2 showed
// LAT cycles later, written in issue order to base+k / base+k+stride.
module tb_pe2_writeback_collector;

   localparam int DEPTH = 4;
   localparam int HIST  = 8192;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        KD_mode;
   logic        sel_1;
   logic [7:0]  base_addr;
   logic [7:0]  stride;
   logic [7:0]  num_pairs;
   logic        issue_valid;
   logic        issue_ready;
   logic [23:0] PE2_out3;
   logic [23:0] PE2_out4;
   logic        wr_en;
   logic        wr_ready;
   logic [7:0]  wr_addr0;
   logic [23:0] wr_data0;
   logic [7:0]  wr_addr1;
   logic [23:0] wr_data1;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   pe2_writeback_collector dut (
      .clk(clk), .rst(rst), .start(start), .KD_mode(KD_mode), .sel_1(sel_1),
      .base_addr(base_addr), .stride(stride), .num_pairs(num_pairs),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .PE2_out3(PE2_out3), .PE2_out4(PE2_out4),
      .wr_en(wr_en), .wr_ready(wr_ready),
      .wr_addr0(wr_addr0), .wr_data0(wr_data0),
      .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .busy(busy), .done(done), .err(err)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference model state
   logic [23:0] hist3 [0:HIST-1];
   logic [23:0] hist4 [0:HIST-1];
   int          iss_cyc [0:255];
   int          m_issued, m_written, m_num, m_lat, m_done_at;
   bit          m_busy, m_err;
   logic [7:0]  m_base, m_stride;

   // Stimulus policy
   bit          g_start, g_rst, g_force_issue, g_chk_zero;
   int          g_issue_pct, g_ready_pct, g_hold;
   logic        g_kd, g_sel;
   logic [7:0]  g_base, g_stride, g_num;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_clear();
      m_issued  = 0;
      m_written = 0;
      m_num     = 0;
      m_lat     = 2;
      m_done_at = -1;
      m_busy    = 1'b0;
      m_err     = 1'b0;
      m_base    = 8'h00;
      m_stride  = 8'h00;
   endtask

   // One clock cycle: compare outputs with the model, drive inputs, advance the model
   task automatic tick();
      bit         e_ready, e_wren, e_busy, acc, wacc;
      logic [7:0] e_a0, e_a1;
      int         cap;
      @(negedge clk);
      cyc++;
      if (cyc >= HIST) begin
         $display("FAIL cycle_budget cycle=%0d got=overrun expected=<%0d", cyc, HIST);
         $fatal(1, "cycle budget exhausted");
      end
      e_busy  = m_busy;
      e_ready = m_busy && (m_issued < m_num) && ((m_issued - m_written) < DEPTH);
      e_wren  = (m_written < m_issued) && (iss_cyc[m_written] + m_lat + 1 <= cyc);
      check("issue_ready", 32'(issue_ready), 32'(e_ready));
      check("wr_en",       32'(wr_en),       32'(e_wren));
      check("busy",        32'(busy),        32'(e_busy));
      check("done",        32'(done),        32'(m_done_at == cyc));
      check("err",         32'(err),         32'(m_err));
      if (e_wren) begin
         cap  = iss_cyc[m_written] + m_lat;
         e_a0 = m_base + 8'(m_written);
         e_a1 = e_a0 + m_stride;
         check("wr_addr0", 32'(wr_addr0), 32'(e_a0));
         check("wr_addr1", 32'(wr_addr1), 32'(e_a1));
         check("wr_data0", 32'(wr_data0), 32'(hist3[cap]));
         check("wr_data1", 32'(wr_data1), 32'(hist4[cap]));
      end
      if (g_chk_zero) begin
         g_chk_zero = 1'b0;
         check("rst_wr_addr0", 32'(wr_addr0), 32'h0);
         check("rst_wr_addr1", 32'(wr_addr1), 32'h0);
         check("rst_wr_data0", 32'(wr_data0), 32'h0);
         check("rst_wr_data1", 32'(wr_data1), 32'h0);
      end

      // Inputs for this cycle
      rst         = g_rst;
      start       = g_start && !g_rst;
      KD_mode     = g_kd;
      sel_1       = g_sel;
      base_addr   = g_base;
      stride      = g_stride;
      num_pairs   = g_num;
      issue_valid = !g_rst && (g_force_issue ||
                    (e_ready && ($urandom_range(99) < 32'(g_issue_pct))));
      if (g_hold > 0) begin
         wr_ready = 1'b0;
         g_hold--;
      end else begin
         wr_ready = ($urandom_range(99) < 32'(g_ready_pct));
      end
      PE2_out3   = 24'($urandom);
      PE2_out4   = 24'($urandom);
      hist3[cyc] = PE2_out3;
      hist4[cyc] = PE2_out4;

      // Model advance
      if (g_rst) begin
         model_clear();
      end else begin
         acc  = issue_valid && e_ready;
         wacc = e_wren && wr_ready;
         if (issue_valid && !e_ready) m_err = 1'b1;
         if (wacc) begin
            $display("write pair=%0d addr0=%02h addr1=%02h data0=%06h data1=%06h",
                     m_written, wr_addr0, wr_addr1, wr_data0, wr_data1);
            m_written++;
            if (m_written == m_num) m_done_at = cyc + 1;
         end
         if (acc) begin
            iss_cyc[m_issued] = cyc;
            m_issued++;
         end
         if (m_done_at == cyc) m_busy = 1'b0;
         if (start && !e_busy) begin
            m_busy    = 1'b1;
            m_issued  = 0;
            m_written = 0;
            m_num     = int'(g_num);
            m_lat     = !g_sel ? 2 : (!g_kd ? 3 : 9);
            m_base    = g_base;
            m_stride  = g_stride;
            if (g_num == 8'd0) m_done_at = cyc + 1;
         end
      end
   endtask

   task automatic run_pass(input logic kd, input logic sel, input logic [7:0] base,
                           input logic [7:0] str, input logic [7:0] num,
                           input int ipct, input int rpct, input int hold,
                           input bit force_iss, input bit restart_mid);
      int guard;
      g_kd = kd; g_sel = sel; g_base = base; g_stride = str; g_num = num;
      g_issue_pct = ipct; g_ready_pct = rpct; g_force_issue = 1'b0;
      g_start = 1'b1;
      tick();
      g_start = 1'b0;
      g_hold = hold;
      g_force_issue = force_iss;
      guard = 0;
      while (m_busy && guard < 2000) begin
         g_start = restart_mid && (guard == 3);
         g_num   = (restart_mid && guard == 3) ? 8'd1 : num;
         g_base  = (restart_mid && guard == 3) ? 8'hA5 : base;
         tick();
         guard++;
      end
      g_start = 1'b0;
      check("pass_finished", 32'(guard < 2000), 32'h1);
      g_force_issue = 1'b0;
      g_hold = 0;
      tick();
      tick();
   endtask

   initial begin
      int guard;
      rst = 1'b1; start = 1'b0; KD_mode = 1'b0; sel_1 = 1'b0;
      base_addr = '0; stride = '0; num_pairs = '0; issue_valid = 1'b0;
      wr_ready = 1'b0; PE2_out3 = '0; PE2_out4 = '0;
      g_start = 0; g_force_issue = 0; g_chk_zero = 0; g_hold = 0;
      g_issue_pct = 100; g_ready_pct = 100;
      g_kd = 0; g_sel = 0; g_base = 0; g_stride = 0; g_num = 0;
      model_clear();

      g_rst = 1'b1;
      tick();
      tick();
      g_rst = 1'b0;
      g_chk_zero = 1'b1;
      tick();

      // DNTT, back-to-back issues
      run_pass(1'b1, 1'b0, 8'h10, 8'h40, 8'd4, 100, 100, 0, 1'b0, 1'b0);
      // DINTT, credit limits in-flight issues
      run_pass(1'b1, 1'b1, 8'h20, 8'h08, 8'd6, 100, 100, 0, 1'b0, 1'b0);
      // KINTT with RAM stalled long enough to fill the FIFO
      run_pass(1'b0, 1'b1, 8'h30, 8'h10, 8'd10, 100, 100, 20, 1'b0, 1'b0);
      // Address wrap
      run_pass(1'($urandom), 1'($urandom), 8'hFE, 8'h02, 8'd3, 70, 70, 0, 1'b0, 1'b0);
      // Random passes
      for (int p = 0; p < 6; p++) begin
         run_pass(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom_range(20, 1)), int'($urandom_range(100, 30)),
                  int'($urandom_range(100, 30)), int'($urandom_range(6, 0)), 1'b0, 1'b0);
      end

      // Reset in the middle of a DINTT pass with three pairs in flight
      g_kd = 1'b1; g_sel = 1'b1; g_base = 8'h50; g_stride = 8'h20; g_num = 8'd8;
      g_issue_pct = 100; g_ready_pct = 100;
      g_start = 1'b1;
      tick();
      g_start = 1'b0;
      guard = 0;
      while (m_issued < 3 && guard < 50) begin
         tick();
         guard++;
      end
      check("mid_pass_issues", 32'(m_issued), 32'd3);
      g_rst = 1'b1;
      tick();
      g_rst = 1'b0;
      g_chk_zero = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      run_pass(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom_range(12, 5)), 80, 80, 0, 1'b0, 1'b0);

      // Illegal issues and a second start while busy, then an empty pass
      run_pass(1'b0, 1'b1, 8'h40, 8'h04, 8'd5, 100, 100, 0, 1'b1, 1'b1);
      run_pass(1'b1, 1'b0, 8'h60, 8'h01, 8'd0, 100, 100, 0, 1'b0, 1'b0);
      run_pass(1'b0, 1'b0, 8'h70, 8'h03, 8'd4, 90, 90, 0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
